// File: rtl/onehot_strobe_decoder.sv
// Sequential 3-to-8 one-hot strobe decoder with a one-entry pending buffer.
// Ports: clk, rst_n, code_in/code_valid/code_ready, d_out, active_code, strobe_done, busy.
module onehot_strobe_decoder #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [7:0] d_out,
  output logic [2:0] active_code,
  output logic       strobe_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LD  = 8'((GAP > 0) ? GAP - 1 : 0);
  localparam logic       NO_GAP  = (GAP == 0);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] act_q, act_d;
  logic       pend_q, pend_d;
  logic [2:0] pcode_q, pcode_d;

  logic accept;
  logic last;
  logic sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      pend_q  <= 1'b0;
      pcode_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pcode_q <= pcode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_q;
    pcode_d = pcode_q;
    accept  = code_valid && !pend_q;
    last    = (cnt_q == 8'd0);
    // selection point: end of the strobe+gap window
    sel     = last && ((state_q == S_HOLD && NO_GAP)
                    || state_q == S_GAP);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          act_d   = code_in;
        end
      end
      S_HOLD: begin
        if (!last) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!NO_GAP) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end
      end
      S_GAP: begin
        if (!last) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        act_d   = '0;
      end
    endcase

    if (sel) begin
      // pending entry wins; else a same-cycle code bypasses the buffer
      if (pend_q) begin
        state_d = S_HOLD;
        cnt_d   = HOLD_LD;
        act_d   = pcode_q;
        pend_d  = 1'b0;
      end else if (accept) begin
        state_d = S_HOLD;
        cnt_d   = HOLD_LD;
        act_d   = code_in;
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
        act_d   = '0;
      end
    end else if (accept && state_q != S_IDLE) begin
      pend_d  = 1'b1;
      pcode_d = code_in;
    end
  end

  assign d_out       = (state_q == S_HOLD) ? (8'd1 << act_q) : 8'd0;
  assign active_code = act_q;
  assign strobe_done = (state_q == S_HOLD) && last;
  assign code_ready  = !pend_q;
  assign busy        = (state_q != S_IDLE) || pend_q;

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Scoreboard bench for onehot_strobe_decoder.
// Two builds: HOLD=4/GAP=1 and HOLD=2/GAP=0.
module tb_onehot_strobe_decoder;

  logic clk;
  int   cyc;
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", n, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int H = (g == 0) ? 4 : 2;
    localparam int G = (g == 0) ? 1 : 0;

    logic       rst_n;
    logic [2:0] code_in;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] d_out;
    logic [2:0] active_code;
    logic       strobe_done;
    logic       busy;

    bit         done_f;
    bit         mon_en;
    logic [2:0] qc[$];
    int         qs[$];
    int         last_end;
    int         lo;
    int         hi;
    bit         in_s;
    int         len;
    logic [2:0] cur;

    onehot_strobe_decoder #(.HOLD(H), .GAP(G)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .d_out      (d_out),
      .active_code(active_code),
      .strobe_done(strobe_done),
      .busy       (busy)
    );

    // Model: a strobe starts at the later of (accept+1) and
    // (previous strobe end + G + 1); the block is not ready
    // while an accepted code waits for its start.
    task automatic step(input logic v, input logic [2:0] c);
      int  s;
      bit  er;
      @(negedge clk);
      er = !(cyc >= lo && cyc <= hi);
      chk("code_ready", int'(code_ready), int'(er));
      code_valid = v;
      code_in    = c;
      if (v && er) begin
        s = cyc + 1;
        if (last_end + G + 1 > s) s = last_end + G + 1;
        if (s > cyc + 1) begin
          lo = cyc + 1;
          hi = s - 1;
        end
        last_end = s + H - 1;
        qc.push_back(c);
        qs.push_back(s);
      end
    endtask

    always @(negedge clk) begin
      if (mon_en) begin
        if (!in_s && d_out != 8'd0) begin
          in_s = 1'b1;
          len  = 0;
          if (qc.size() == 0) begin
            chk("unexpected_strobe", int'(d_out), 0);
            cur = 3'd0;
          end else begin
            cur = qc.pop_front();
            chk("start_cycle", cyc, qs.pop_front());
          end
        end
        if (in_s) begin
          len++;
          chk("d_out", int'(d_out), int'(8'd1 << cur));
          chk("active_code", int'(active_code), int'(cur));
          chk("strobe_done", int'(strobe_done), int'(len == H));
          if (len == H) in_s = 1'b0;
        end else begin
          chk("idle_strobe_done", int'(strobe_done), 0);
        end
      end
    end

    initial begin
      done_f     = 1'b0;
      mon_en     = 1'b0;
      in_s       = 1'b0;
      len        = 0;
      cur        = '0;
      rst_n      = 1'b0;
      code_valid = 1'b1;
      code_in    = 3'd5;
      last_end   = -1000;
      lo         = 1;
      hi         = 0;
      repeat (3) @(negedge clk);
      chk("rst_d_out", int'(d_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_code_ready", int'(code_ready), 1);
      chk("rst_strobe_done", int'(strobe_done), 0);
      code_valid = 1'b0;
      rst_n      = 1'b1;
      mon_en     = 1'b1;

      step(1'b0, 3'd0);
      step(1'b1, 3'd5);
      repeat (8) step(1'b0, 3'd0);
      step(1'b1, 3'd0);
      step(1'b1, 3'd7);
      repeat (12) step(1'b0, 3'd0);
      // code presented only at the selection point
      step(1'b1, 3'd1);
      repeat (H + G - 1) step(1'b0, 3'd0);
      step(1'b1, 3'd3);
      repeat (8) step(1'b0, 3'd0);
      step(1'b1, 3'd1);
      step(1'b1, 3'd2);
      repeat (8) step(1'b0, 3'd0);

      for (int i = 0; i < 400; i++) begin
        step(1'($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)));
      end
      repeat (H + G + 10) step(1'b0, 3'($urandom_range(0, 7)));
      chk("drain_busy", int'(busy), 0);
      chk("drain_queue", qc.size(), 0);
      chk("drain_in_strobe", int'(in_s), 0);

      mon_en = 1'b0;
      @(negedge clk);
      code_valid = 1'b1;
      code_in    = 3'd6;
      @(negedge clk);
      chk("ar_d_out_c1", int'(d_out), 8'h40);
      code_in = 3'd2;
      @(negedge clk);
      code_valid = 1'b0;
      chk("ar_d_out_c2", int'(d_out), 8'h40);
      chk("ar_pending", int'(code_ready), 0);
      rst_n = 1'b0;
      #1;
      chk("ar_d_out_async", int'(d_out), 0);
      chk("ar_busy_async", int'(busy), 0);
      chk("ar_ready_async", int'(code_ready), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        chk("ar_no_stale", int'(d_out), 0);
      end
      done_f = 1'b1;
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (cfg[0].done_f && cfg[1].done_f) break;
    end
    if (!(cfg[0].done_f && cfg[1].done_f)) chk("timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onehot_strobe_decoder.md
Name: onehot_strobe_decoder

Overview:
- Sequential 3-to-8 one-hot decoder: the decode side of the team's 8:3 one-hot encoder.
- Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot output line for HOLD cycles, then a GAP of all-zero cycles.
- One-entry pending buffer allows back-to-back codes with no idle bubbles beyond GAP.
- Drives strobe/select lines (e.g. chip selects, row enables) from a compact code stream.

Parameters:
HOLD, 4, cycles each decoded line stays asserted (legal range 1..255)
GAP, 1, all-zero cycles between consecutive strobes (legal range 0..255)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
code_in  input  3  code to decode (0..7)
code_valid  input  1  code_in valid this cycle
code_ready  output  1  block can accept a code; equals NOT pend_valid
d_out  output  8  one-hot decoded output; bit code_in set during HOLD, else 8'b0
active_code  output  3  code currently driven (0 when idle)
strobe_done  output  1  one-cycle pulse in the last HOLD cycle of each strobe
busy  output  1  state != IDLE or pending entry valid

Behaviour:
- Reset (rst_n low, async): state=IDLE, counter=0, pend_valid=0, d_out=0, active_code=0, strobe_done=0, busy=0, code_ready=1. A code in flight or pending is discarded.
- Accept: code_valid AND code_ready at a rising edge. code_in is ignored when code_valid is low.
- FSM states: IDLE, HOLD, GAP; down-counter 8 bits.
- IDLE: on accept -> HOLD next cycle, d_out = 1<<code, counter=HOLD-1. Latency from accept edge to d_out asserted = 1 cycle (registered output).
- HOLD: d_out held; counter decrements. strobe_done=1 while counter==0. At counter==0:
  - GAP>0: -> GAP, counter=GAP-1, d_out=0.
  - GAP=0: next-code selection (below).
- GAP: d_out=0; counter decrements. At counter==0: next-code selection.
- Next-code selection, in priority order:
  - pend_valid: load the pending code -> HOLD, pend_valid cleared.
  - Else, accept in the same cycle: the incoming code bypasses the buffer -> HOLD.
  - Else -> IDLE, d_out=0, active_code=0.
- Pending buffer: accept while in HOLD/GAP and not at a selection point -> stored, pend_valid=1. code_ready drops the next cycle and stays low until the buffer is loaded.
- Throughput: one code per HOLD+GAP cycles sustained.
- d_out is always one-hot or zero; never multi-hot.
- active_code tracks the code driving d_out during HOLD and holds it through GAP; 0 in IDLE.

Test Plan:
- Reset: rst_n low with code_valid=1, code_in=5 -> d_out=0, busy=0, code_ready=1, no accept; release -> IDLE.
- Single code (HOLD=4, GAP=1): code 5 accepted at cycle 0 -> d_out=8'h20 cycles 1-4; strobe_done=1 cycle 4 only; d_out=0 cycle 5; busy=0 from cycle 6.
- Back-to-back: code 0 accepted cycle 0, code 7 valid cycle 1 -> code 7 accepted cycle 1 (pending); code_ready=0 cycles 2-5, =1 cycle 6; d_out=8'h01 cycles 1-4, 0 cycle 5, 8'h80 cycles 6-9.
- Bypass: buffer empty, code 3 presented only in the final GAP cycle -> d_out=8'h08 the next cycle, no IDLE cycle, pend_valid never set.
- Async reset mid-HOLD: rst_n low in cycle 2 of a code-6 strobe with code 2 pending -> d_out=0 immediately (before next edge); after release code 2 never appears.
- GAP=0 build: codes 1 then 2 queued -> d_out goes 8'h02 directly to 8'h04 with no zero cycle; strobe_done pulses once per strobe.
